// File: rtl/vec_fifo_pkg.sv
// rtl/vec_fifo_pkg.sv - shared types and constants for the vec3 pair feeder and its FIFO wrapper
package vec_fifo_pkg;

    localparam int VEC_DATA_WIDTH = 32;
    localparam int WORDS_PER_VEC  = 3;
    localparam int WORDS_PER_PAIR = 6;
    localparam int IDX_WIDTH      = $clog2(WORDS_PER_PAIR);

    typedef enum logic {
        S_COLLECT = 1'b0,
        S_WRITE   = 1'b1
    } state_e;

endpackage

// File: rtl/fifo_array.sv
// rtl/fifo_array.sv - synchronous FWFT FIFO whose entries are ARRAY_SIZE words wide
module fifo_array #(
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int ARRAY_SIZE      = 6,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [FIFO_DATA_WIDTH-1:0] din [ARRAY_SIZE-1:0],
    output logic                       full,
    input  logic                       rd_en,
    output logic [FIFO_DATA_WIDTH-1:0] dout [ARRAY_SIZE-1:0],
    output logic                       empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [FIFO_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH][ARRAY_SIZE];
    logic [AW:0]                wr_ptr_q, wr_ptr_d;
    logic [AW:0]                rd_ptr_q, rd_ptr_d;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en && !full) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en && !empty) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en && !full) begin
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                mem_q[wr_ptr_q[AW-1:0]][i] <= din[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            dout[i] = mem_q[rd_ptr_q[AW-1:0]][i];
        end
    end

endmodule

// File: rtl/vec3_pair_assembler_fifo.sv
// rtl/vec3_pair_assembler_fifo.sv - pair assembler feeding a 6-wide FIFO read by the cross/dot stages
module vec3_pair_assembler_fifo
    import vec_fifo_pkg::*;
#(
    parameter int FIFO_DATA_WIDTH = VEC_DATA_WIDTH,
    parameter int COUNT_WIDTH     = 16,
    parameter int FIFO_DEPTH      = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_empty,
    input  logic [FIFO_DATA_WIDTH-1:0] in_dout,
    output logic                       in_rd_en,
    input  logic                       out_rd_en,
    output logic                       out_empty,
    output logic [FIFO_DATA_WIDTH-1:0] dout [WORDS_PER_PAIR-1:0],
    output logic                       busy,
    output logic [COUNT_WIDTH-1:0]     pair_count
);

    logic                       wr_en;
    logic                       full;
    logic [FIFO_DATA_WIDTH-1:0] x [2:0];
    logic [FIFO_DATA_WIDTH-1:0] y [2:0];
    logic [FIFO_DATA_WIDTH-1:0] din [WORDS_PER_PAIR-1:0];

    vec3_pair_assembler #(
        .DATA_WIDTH  (FIFO_DATA_WIDTH),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_core (
        .clock      (clock),
        .reset      (reset),
        .in_empty   (in_empty),
        .in_dout    (in_dout),
        .in_rd_en   (in_rd_en),
        .out_full   (full),
        .out_wr_en  (wr_en),
        .out_x      (x),
        .out_y      (y),
        .busy       (busy),
        .pair_count (pair_count)
    );

    // Entry layout is {y, x}: x in the low three words, y in the high three.
    always_comb begin
        for (int i = 0; i < WORDS_PER_VEC; i++) begin
            din[i]                 = x[i];
            din[i + WORDS_PER_VEC] = y[i];
        end
    end

    fifo_array #(
        .FIFO_DATA_WIDTH (FIFO_DATA_WIDTH),
        .ARRAY_SIZE      (WORDS_PER_PAIR),
        .FIFO_DEPTH      (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .wr_en (wr_en),
        .din   (din),
        .full  (full),
        .rd_en (out_rd_en),
        .dout  (dout),
        .empty (out_empty)
    );

endmodule

// File: rtl/vec3_pair_assembler.sv
// rtl/vec3_pair_assembler.sv - groups six serial scalars into an (x, y) vec3 pair and writes it out
module vec3_pair_assembler
    import vec_fifo_pkg::*;
#(
    parameter int DATA_WIDTH  = VEC_DATA_WIDTH,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_empty,
    input  logic [DATA_WIDTH-1:0]  in_dout,
    output logic                   in_rd_en,
    input  logic                   out_full,
    output logic                   out_wr_en,
    output logic [DATA_WIDTH-1:0]  out_x [2:0],
    output logic [DATA_WIDTH-1:0]  out_y [2:0],
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] pair_count
);

    localparam logic [IDX_WIDTH-1:0] FIRST_Y  = IDX_WIDTH'(WORDS_PER_VEC);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(WORDS_PER_PAIR - 1);

    state_e                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic [DATA_WIDTH-1:0]  x_q [2:0];
    logic [DATA_WIDTH-1:0]  x_d [2:0];
    logic [DATA_WIDTH-1:0]  y_q [2:0];
    logic [DATA_WIDTH-1:0]  y_d [2:0];
    logic [COUNT_WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        x_d       = x_q;
        y_d       = y_q;
        count_d   = count_q;
        in_rd_en  = 1'b0;
        out_wr_en = 1'b0;

        case (state_q)
            S_COLLECT: begin
                if (!in_empty) begin
                    in_rd_en = 1'b1;
                    if (idx_q < FIRST_Y) begin
                        x_d[idx_q] = in_dout;
                    end else begin
                        y_d[idx_q - FIRST_Y] = in_dout;
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_WRITE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                // Registers hold while stalled so the FIFO sees a stable pair.
                if (!out_full) begin
                    out_wr_en = 1'b1;
                    count_d   = count_q + COUNT_WIDTH'(1);
                    state_d   = S_COLLECT;
                end
            end
            default: begin
                state_d = S_COLLECT;
                idx_d   = '0;
            end
        endcase

        if (reset) begin
            in_rd_en  = 1'b0;
            out_wr_en = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
            x_q     <= '{default: '0};
            y_q     <= '{default: '0};
            count_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
            y_q     <= y_d;
            count_q <= count_d;
        end
    end

    assign out_x      = x_q;
    assign out_y      = y_q;
    assign pair_count = count_q;
    assign busy       = (idx_q != '0) || (state_q == S_WRITE);

endmodule

// File: tb/tb_vec3_pair_assembler.sv
// tb/tb_vec3_pair_assembler.sv - directed self-checking bench for vec3_pair_assembler
module tb_vec3_pair_assembler;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_empty = 1'b1;
    logic [31:0] in_dout = '0;
    logic        out_full = 1'b0;

    logic        rd16, wr16, busy16;
    logic [31:0] x16 [2:0];
    logic [31:0] y16 [2:0];
    logic [15:0] cnt16;

    logic        rd4, wr4, busy4;
    logic [31:0] x4 [2:0];
    logic [31:0] y4 [2:0];
    logic [3:0]  cnt4;

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    vec3_pair_assembler #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout),
        .in_rd_en(rd16), .out_full(out_full), .out_wr_en(wr16),
        .out_x(x16), .out_y(y16), .busy(busy16), .pair_count(cnt16)
    );

    vec3_pair_assembler #(.DATA_WIDTH(32), .COUNT_WIDTH(4)) dut_c4 (
        .clock(clock), .reset(reset), .in_empty(in_empty), .in_dout(in_dout),
        .in_rd_en(rd4), .out_full(out_full), .out_wr_en(wr4),
        .out_x(x4), .out_y(y4), .busy(busy4), .pair_count(cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic empty, input logic [31:0] data, input logic full);
        @(negedge clock);
        in_empty = empty;
        in_dout  = data;
        out_full = full;
        #1;
    endtask

    task automatic check_pair(input string tag, input int x0, input int x1, input int x2,
                              input int y0, input int y1, input int y2);
        check({tag, "_x0"}, x16[0], x0);
        check({tag, "_x1"}, x16[1], x1);
        check({tag, "_x2"}, x16[2], x2);
        check({tag, "_y0"}, y16[0], y0);
        check({tag, "_y1"}, y16[1], y1);
        check({tag, "_y2"}, y16[2], y2);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b0;
        out_full = 1'b0;
        #1;
        check("rst_rd_forced", 32'(rd16), 0);
        check("rst_wr_forced", 32'(wr16), 0);
        check("rst_busy", 32'(busy16), 0);
        check("rst_cnt", 32'(cnt16), 0);
        @(negedge clock);
        in_empty = 1'b1;
        reset    = 1'b0;
    endtask

    task automatic push(input string tag, input int data);
        step(1'b0, data, 1'b0);
        check({tag, "_rd"}, 32'(rd16), 1);
        check({tag, "_wr"}, 32'(wr16), 0);
    endtask

    task automatic gap(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 32'hdead_beef, 1'b0);
            check({tag, "_gap_rd"}, 32'(rd16), 0);
            check({tag, "_gap_wr"}, 32'(wr16), 0);
        end
    endtask

    // Write cycle: upstream still offers a word to prove no pop happens here.
    task automatic expect_write(input string tag, input int exp_cnt);
        step(1'b0, 32'h0bad_0bad, 1'b0);
        check({tag, "_wr"}, 32'(wr16), 1);
        check({tag, "_rd"}, 32'(rd16), 0);
        @(posedge clock);
        #1;
        check({tag, "_cnt"}, 32'(cnt16), exp_cnt);
    endtask

    initial begin
        int q[$];
        int wr_cycles[$];
        int rd_total;

        // Reset state
        #1;
        check("por_x0", x16[0], 0);
        check("por_y2", y16[2], 0);
        check("por_cnt", 32'(cnt16), 0);
        check("por_busy", 32'(busy16), 0);
        do_reset();

        // T1: back to back 1..6
        for (int i = 1; i <= 6; i++) push("t1", i);
        check("t1_busy", 32'(busy16), 1);
        step(1'b0, 32'h0bad_0bad, 1'b0);
        check("t1_wr", 32'(wr16), 1);
        check("t1_rd", 32'(rd16), 0);
        check_pair("t1", 1, 2, 3, 4, 5, 6);
        check("t1_cnt_pre", 32'(cnt16), 0);
        @(posedge clock);
        #1;
        check("t1_cnt", 32'(cnt16), 1);
        gap("t1_after", 1);
        check("t1_busy_idle", 32'(busy16), 0);

        // T2: gaps of 2 after words 2 and 4, write in cycle 11
        do_reset();
        push("t2", 1); push("t2", 2);
        gap("t2a", 2);
        push("t2", 3); push("t2", 4);
        gap("t2b", 2);
        push("t2", 5); push("t2", 6);
        step(1'b0, 32'h0bad_0bad, 1'b0);
        check("t2_wr", 32'(wr16), 1);
        check_pair("t2", 1, 2, 3, 4, 5, 6);
        @(posedge clock);
        #1;
        check("t2_cnt", 32'(cnt16), 1);

        // T3: out_full stall for 3 cycles on entering S_WRITE
        do_reset();
        for (int i = 21; i <= 26; i++) push("t3", i);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'h0bad_0bad, 1'b1);
            check("t3_stall_wr", 32'(wr16), 0);
            check("t3_stall_rd", 32'(rd16), 0);
            check("t3_stall_busy", 32'(busy16), 1);
            check_pair("t3_stall", 21, 22, 23, 24, 25, 26);
            check("t3_stall_cnt", 32'(cnt16), 0);
        end
        expect_write("t3", 1);
        check_pair("t3_post", 21, 22, 23, 24, 25, 26);

        // T4: -1..-12 back to back, writes 7 cycles apart
        do_reset();
        for (int i = 1; i <= 12; i++) q.push_back(-i);
        rd_total = 0;
        for (int cyc = 0; cyc < 14; cyc++) begin
            if (q.size() > 0) step(1'b0, q[0], 1'b0);
            else              step(1'b1, 32'h0, 1'b0);
            if (wr16) begin
                wr_cycles.push_back(cyc);
                if (wr_cycles.size() == 2) check_pair("t4_p2", -7, -8, -9, -10, -11, -12);
                else                       check_pair("t4_p1", -1, -2, -3, -4, -5, -6);
            end
            if (rd16) begin
                rd_total++;
                void'(q.pop_front());
            end
        end
        check("t4_nwrites", wr_cycles.size(), 2);
        check("t4_nreads", rd_total, 12);
        if (wr_cycles.size() == 2) begin
            check("t4_wr1_cyc", wr_cycles[0], 6);
            check("t4_wr2_cyc", wr_cycles[1], 13);
        end
        @(posedge clock);
        #1;
        check("t4_cnt", 32'(cnt16), 2);

        // T5: reset after 4 words discards partial pair
        do_reset();
        for (int i = 1; i <= 4; i++) push("t5a", i);
        check("t5_busy_mid", 32'(busy16), 1);
        @(negedge clock);
        reset    = 1'b1;
        in_empty = 1'b0;
        #1;
        check("t5_rst_rd", 32'(rd16), 0);
        check("t5_rst_wr", 32'(wr16), 0);
        check("t5_rst_busy", 32'(busy16), 0);
        @(negedge clock);
        reset    = 1'b0;
        in_empty = 1'b1;
        for (int i = 10; i <= 15; i++) push("t5b", i);
        step(1'b0, 32'h0bad_0bad, 1'b0);
        check("t5_wr", 32'(wr16), 1);
        check_pair("t5", 10, 11, 12, 13, 14, 15);
        @(posedge clock);
        #1;
        check("t5_cnt", 32'(cnt16), 1);
        gap("t5_after", 2);

        // T6: 17 pairs, 4-bit counter wraps
        do_reset();
        for (int p = 1; p <= 17; p++) begin
            for (int i = 0; i < 6; i++) push("t6", p * 16 + i);
            expect_write("t6", p);
            check("t6_cnt4", 32'(cnt4), p % 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vec3_pair_assembler.md
Name: vec3_pair_assembler

Overview:
- Feeder for the vector-math stage. Pops a serial stream of 32-bit Q-format scalars from an upstream FWFT FIFO.
- Groups each six consecutive words in the order x[0], x[1], x[2], y[0], y[1], y[2].
- Writes each assembled pair into a 6-wide output FIFO (a fifo_array of ARRAY_SIZE 6).
- That FIFO's empty/dout drive the in_empty/x/y inputs of the cross/dot stages. This block is the writer end of that FIFO interface.

Parameters:
- DATA_WIDTH, 32, scalar width in bits (signed Q-format, passed through unmodified).
- COUNT_WIDTH, 16, width of the pair_count statistics counter.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- in_empty  input  1  upstream FIFO empty; in_dout valid whenever low (FWFT)
- in_dout  input  DATA_WIDTH  upstream head word, signed
- in_rd_en  output  1  pop upstream head word this cycle
- out_full  input  1  output FIFO full
- out_wr_en  output  1  write out_x/out_y into output FIFO this cycle
- out_x  output  DATA_WIDTH x3 (unpacked [2:0])  assembled vector x
- out_y  output  DATA_WIDTH x3 (unpacked [2:0])  assembled vector y
- busy  output  1  high when 1..5 words of a pair are held, or in S_WRITE
- pair_count  output  COUNT_WIDTH  pairs written since reset, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (async, active-high) sets:
  - state = S_COLLECT, idx = 0
  - out_x, out_y, pair_count = 0
- in_rd_en and out_wr_en are combinational, and are forced 0 while reset is high. busy = 0 after reset.
- State S_COLLECT:
  - If !in_empty: in_rd_en = 1, in_dout is registered into slot idx, and idx increments. Slots 0-2 map to out_x[0..2]; slots 3-5 map to out_y[0..2].
  - When the word in slot 5 is captured: idx <= 0 and next state = S_WRITE.
  - If in_empty: nothing changes and no pop occurs. Gaps of any length are legal.
- State S_WRITE:
  - in_rd_en = 0.
  - If !out_full: out_wr_en = 1, pair_count increments, next state = S_COLLECT.
  - If out_full: stay in S_WRITE and hold all registers. out_x/out_y must stay stable until the write occurs.
- Timing and throughput:
  - Latency: with no stalls, out_wr_en rises in the cycle after the 6th pop.
  - Maximum throughput is one pair per 7 cycles. Collection and write never overlap; there is no pop in S_WRITE.
- out_x/out_y during S_COLLECT:
  - They update slot by slot and are only meaningful while out_wr_en = 1.
  - Unwritten slots keep the previous pair's values; they are not cleared between pairs.
- in_rd_en is never asserted while in_empty = 1. out_wr_en is never asserted while out_full = 1.
- Reset mid-collection discards the partial pair: idx = 0 and no write is issued. The next six words form a fresh pair.
- pair_count wraps from 2^COUNT_WIDTH-1 to 0 without any flag.
- No arithmetic on data: words are passed bit-exact, with no sign extension or shift.

Decomposition:
- Shared package (vec_fifo_pkg):
  - state enum {S_COLLECT, S_WRITE}
  - constants WORDS_PER_VEC = 3 and WORDS_PER_PAIR = 6
  - DATA_WIDTH default
- No sub-module inside the core.
- Separate wrapper vec3_pair_assembler_fifo instantiates the core plus fifo_array:
  - FIFO_DATA_WIDTH = 32, ARRAY_SIZE = 6, din = {y, x}
  - exposes out_rd_en / out_empty / dout, in the same way the Cross wrapper does.

Test Plan:
- Push 1,2,3,4,5,6 with in_empty low continuously and out_full low.
  - Expected: in_rd_en high for 6 cycles, then out_wr_en pulses once in cycle 7.
  - out_x = {3,2,1} ([2:0]), out_y = {6,5,4}, pair_count = 1.
- Same six words with in_empty high for 2 cycles after words 2 and 4.
  - Expected: no pops during the gaps, identical output values, out_wr_en in cycle 11.
- Hold out_full high for 3 cycles when S_WRITE is entered.
  - Expected: out_wr_en stays 0 and out_x/out_y stay stable.
  - Write occurs on the first cycle with out_full low; no in_rd_en during the stall.
- Push 12 words (-1 .. -12, two's complement), back to back.
  - Expected: exactly two writes, 7 cycles apart.
  - Pair 2 is out_x = {-9,-8,-7}, out_y = {-12,-11,-10}, pair_count = 2.
- Assert reset after 4 words have been popped, then push 10..15.
  - Expected: no write from the partial pair.
  - Single write with out_x = {12,11,10}, out_y = {15,14,13}, pair_count = 1.
- COUNT_WIDTH = 4, stream 17 pairs.
  - Expected: pair_count reads 15 after pair 15, 0 after pair 16, 1 after pair 17.
